// File: rtl/io_bus_arbiter_pkg.sv
// Shared types and constants for the round-robin I/O bus arbiter.
// The optional wait-for-ack timeout is enabled by defining IOARB_TIMEOUT_EN.
package io_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACKED,
        LOCK
    } arb_state_t;

    localparam int unsigned DEF_NMST = 4;
    localparam int unsigned DEF_WID  = 32;
    localparam int unsigned DEF_AWID = 32;

    // Read data returned on a bus error; sliced down to the data width in use.
    localparam logic [63:0] ERR_DATA = '1;

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Requester-side and master-side bus bundle of io_bus_arbiter.
// slave: the arbiter's view; master: the requesters plus downstream slave.
interface io_bus_arbiter_if
    import io_arb_pkg::*;
#(
    parameter int unsigned NMST = DEF_NMST,
    parameter int unsigned WID  = DEF_WID,
    parameter int unsigned AWID = DEF_AWID
);
    localparam int unsigned SW = WID / 8;
    localparam int unsigned GW = $clog2(NMST);

    logic [NMST-1:0]      s_cyc_i;
    logic [NMST-1:0]      s_stb_i;
    logic [NMST-1:0]      s_we_i;
    logic [NMST*SW-1:0]   s_sel_i;
    logic [NMST*AWID-1:0] s_adr_i;
    logic [NMST*WID-1:0]  s_dat_i;
    logic [NMST-1:0]      s_ack_o;
    logic [NMST-1:0]      s_err_o;
    logic [WID-1:0]       s_dat_o;

    logic                 m_cyc_o;
    logic                 m_stb_o;
    logic                 m_we_o;
    logic [SW-1:0]        m_sel_o;
    logic [AWID-1:0]      m_adr_o;
    logic [WID-1:0]       m_dat_o;
    logic                 m_ack_i;
    logic [WID-1:0]       m_dat_i;

    logic [GW-1:0]        gnt_o;

    modport slave (
        input  s_cyc_i, s_stb_i, s_we_i, s_sel_i, s_adr_i, s_dat_i,
        output s_ack_o, s_err_o, s_dat_o,
        output m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
        input  m_ack_i, m_dat_i,
        output gnt_o
    );

    modport master (
        output s_cyc_i, s_stb_i, s_we_i, s_sel_i, s_adr_i, s_dat_i,
        input  s_ack_o, s_err_o, s_dat_o,
        input  m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
        output m_ack_i, m_dat_i,
        input  gnt_o
    );

endinterface

// File: rtl/io_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after i_last, wrapping.
module rr_pick #(
    parameter  int unsigned NMST = 4,
    localparam int unsigned GW   = $clog2(NMST)
) (
    input  logic [NMST-1:0] i_req,
    input  logic [GW-1:0]   i_last,
    output logic            o_valid,
    output logic [GW-1:0]   o_gnt
);

    logic [GW-1:0] w_idx;

    always_comb begin
        o_valid = 1'b0;
        o_gnt   = '0;
        w_idx   = '0;
        for (int unsigned i = 1; i <= NMST; i++) begin
            w_idx = GW'((32'(i_last) + i) % NMST);
            if (!o_valid && i_req[w_idx]) begin
                o_valid = 1'b1;
                o_gnt   = w_idx;
            end
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing one registered I/O master bus between NMST requesters.
// Define IOARB_TIMEOUT_EN to build the wait-for-ack timeout (bus error after TO_CYCLES).
module io_bus_arbiter
    import io_arb_pkg::*;
#(
    parameter int unsigned NMST      = DEF_NMST,
    parameter int unsigned WID       = DEF_WID,
    parameter int unsigned AWID      = DEF_AWID,
    parameter int unsigned TO_CYCLES = 255
) (
    input  logic           clk_i,
    input  logic           rst_i,
    io_bus_arbiter_if.slave bus
);

    localparam int unsigned SW = WID / 8;
    localparam int unsigned GW = $clog2(NMST);

    arb_state_t      r_state, w_state;
    logic [GW-1:0]   r_gnt, w_gnt;
    logic [GW-1:0]   r_last, w_last;
    logic            r_m_cyc, w_m_cyc;
    logic            r_m_we, w_m_we;
    logic [SW-1:0]   r_m_sel, w_m_sel;
    logic [AWID-1:0] r_m_adr, w_m_adr;
    logic [WID-1:0]  r_m_dat, w_m_dat;
    logic [NMST-1:0] r_s_ack, w_s_ack;
    logic [NMST-1:0] r_s_err, w_s_err;
    logic [WID-1:0]  r_s_dat, w_s_dat;

`ifdef IOARB_TIMEOUT_EN
    localparam int unsigned  TW      = $clog2(TO_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYCLES - 1);
    logic [TW-1:0] r_to_cnt, w_to_cnt;
`endif

    logic [SW-1:0]   w_sel [NMST];
    logic [AWID-1:0] w_adr [NMST];
    logic [WID-1:0]  w_dat [NMST];

    for (genvar k = 0; k < NMST; k++) begin : g_unpack
        assign w_sel[k] = bus.s_sel_i[k*SW +: SW];
        assign w_adr[k] = bus.s_adr_i[k*AWID +: AWID];
        assign w_dat[k] = bus.s_dat_i[k*WID +: WID];
    end

    logic [NMST-1:0] w_req;
    logic            w_pick_vld;
    logic [GW-1:0]   w_pick;
    logic [GW-1:0]   w_src;

    assign w_req = bus.s_cyc_i & bus.s_stb_i;

    rr_pick #(.NMST(NMST)) u_pick (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_valid (w_pick_vld),
        .o_gnt   (w_pick)
    );

    // Bus fields come from the fresh pick in IDLE, otherwise from the held grant.
    assign w_src = (r_state == IDLE) ? w_pick : r_gnt;

    always_comb begin
        w_state = r_state;
        w_gnt   = r_gnt;
        w_last  = r_last;
        w_m_cyc = r_m_cyc;
        w_m_we  = r_m_we;
        w_m_sel = r_m_sel;
        w_m_adr = r_m_adr;
        w_m_dat = r_m_dat;
        w_s_ack = r_s_ack;
        w_s_err = r_s_err;
        w_s_dat = r_s_dat;
`ifdef IOARB_TIMEOUT_EN
        w_to_cnt = r_to_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_gnt   = w_pick;
                    w_m_cyc = 1'b1;
                    w_m_we  = bus.s_we_i[w_src];
                    w_m_sel = w_sel[w_src];
                    w_m_adr = w_adr[w_src];
                    w_m_dat = w_dat[w_src];
                    w_state = BUSY;
`ifdef IOARB_TIMEOUT_EN
                    w_to_cnt = '0;
`endif
                end
            end
            BUSY: begin
                // Abort takes priority over a same-cycle ack (and timeout).
                if (!bus.s_cyc_i[r_gnt]) begin
                    w_m_cyc = 1'b0;
                    w_m_we  = 1'b0;
                    w_m_sel = '0;
                    w_m_adr = '0;
                    w_m_dat = '0;
                    w_state = IDLE;
                end else if (bus.m_ack_i) begin
                    w_s_ack[r_gnt] = 1'b1;
                    w_s_dat = r_m_we ? r_m_dat : bus.m_dat_i;
                    w_m_cyc = 1'b0;
                    w_m_we  = 1'b0;
                    w_m_sel = '0;
                    w_m_adr = '0;
                    w_m_dat = '0;
                    w_state = ACKED;
`ifdef IOARB_TIMEOUT_EN
                end else if (r_to_cnt == TO_LAST) begin
                    w_s_err[r_gnt] = 1'b1;
                    w_s_dat = ERR_DATA[WID-1:0];
                    w_m_cyc = 1'b0;
                    w_m_we  = 1'b0;
                    w_m_sel = '0;
                    w_m_adr = '0;
                    w_m_dat = '0;
                    w_state = ACKED;
`endif
                end else begin
                    w_m_we  = bus.s_we_i[w_src];
                    w_m_sel = w_sel[w_src];
                    w_m_adr = w_adr[w_src];
                    w_m_dat = w_dat[w_src];
`ifdef IOARB_TIMEOUT_EN
                    w_to_cnt = r_to_cnt + 1'b1;
`endif
                end
            end
            ACKED: begin
                if (!bus.s_stb_i[r_gnt]) begin
                    w_s_ack = '0;
                    w_s_err = '0;
                    w_s_dat = '0;
                    w_last  = r_gnt;
                    w_state = bus.s_cyc_i[r_gnt] ? LOCK : IDLE;
                end
            end
            LOCK: begin
                if (!bus.s_cyc_i[r_gnt]) begin
                    w_state = IDLE;
                end else if (bus.s_stb_i[r_gnt]) begin
                    w_m_cyc = 1'b1;
                    w_m_we  = bus.s_we_i[w_src];
                    w_m_sel = w_sel[w_src];
                    w_m_adr = w_adr[w_src];
                    w_m_dat = w_dat[w_src];
                    w_state = BUSY;
`ifdef IOARB_TIMEOUT_EN
                    w_to_cnt = '0;
`endif
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_last  <= GW'(NMST - 1);
            r_m_cyc <= 1'b0;
            r_m_we  <= 1'b0;
            r_m_sel <= '0;
            r_m_adr <= '0;
            r_m_dat <= '0;
            r_s_ack <= '0;
            r_s_err <= '0;
            r_s_dat <= '0;
`ifdef IOARB_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
        end else begin
            r_state <= w_state;
            r_gnt   <= w_gnt;
            r_last  <= w_last;
            r_m_cyc <= w_m_cyc;
            r_m_we  <= w_m_we;
            r_m_sel <= w_m_sel;
            r_m_adr <= w_m_adr;
            r_m_dat <= w_m_dat;
            r_s_ack <= w_s_ack;
            r_s_err <= w_s_err;
            r_s_dat <= w_s_dat;
`ifdef IOARB_TIMEOUT_EN
            r_to_cnt <= w_to_cnt;
`endif
        end
    end

    assign bus.m_cyc_o = r_m_cyc;
    assign bus.m_stb_o = r_m_cyc;
    assign bus.m_we_o  = r_m_we;
    assign bus.m_sel_o = r_m_sel;
    assign bus.m_adr_o = r_m_adr;
    assign bus.m_dat_o = r_m_dat;
    assign bus.s_ack_o = r_s_ack;
    assign bus.s_err_o = r_s_err;
    assign bus.s_dat_o = r_s_dat;
    assign bus.gnt_o   = r_gnt;

endmodule
